cnn_frame_feeder: RTL and testbench

Captures one 28×28 8-bit grayscale frame from the camera pixel stream into a local buffer, then replays it as a single contiguous byte burst on the `data_in`/`data_in_valid` input of `Mini_LeNet`. It is the transmit side of the classifier's input stream, replacing the file-driven stimulus used in simulation. It sits between the camera crop/downscale stage and `Mini_LeNet`, in the `Mini_LeNet` clock domain.

---
 rtl/cnn_feed_pkg.sv | 23 ++
 rtl/sdp_ram.sv | 38 +++
 rtl/cnn_frame_feeder.sv | 148 ++++++++++++++
 tb/tb_cnn_frame_feeder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cnn_feed_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cnn_feed_pkg
// Brief    : Shared frame geometry and FSM state type for the CNN frame feeder.
// Revision : 1.0 - initial release
// ============================================================================
package cnn_feed_pkg;

    localparam int N_PIX  = 784;
    localparam int IMG_W  = 28;
    localparam int PIX_W  = 8;
    localparam int ADDR_W = $clog2(N_PIX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } feed_state_t;

endpackage : cnn_feed_pkg
`default_nettype wire

// File: rtl/sdp_ram.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sdp_ram
// Brief    : Simple dual-port RAM, one write port, one registered read port.
// Revision : 1.0 - initial release
// ============================================================================
module sdp_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 784,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // No reset on storage or read register so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : sdp_ram
`default_nettype wire

// File: rtl/cnn_frame_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cnn_frame_feeder
// Brief    : Captures one camera frame, then replays it as a padded burst.
// Revision : 1.0 - initial release
// ============================================================================
module cnn_frame_feeder #(
    parameter int N_PIX      = cnn_feed_pkg::N_PIX,
    parameter int PAD_BEATS  = 1,
    parameter int GAP_CYCLES = 16,
    parameter int DATA_W     = cnn_feed_pkg::PIX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_in_valid,
    input  logic              pix_sof,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_valid,
    output logic              frame_done,
    output logic              busy,
    output logic [7:0]        drop_cnt
);

    import cnn_feed_pkg::*;

    localparam int AW        = $clog2(N_PIX);
    localparam int BURST_LEN = PAD_BEATS + N_PIX;
    localparam int BW        = $clog2(BURST_LEN + 1);
    localparam int GW        = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

    feed_state_t       r_state;
    logic [AW-1:0]     r_wr_addr;
    logic [BW-1:0]     r_beat_cnt;
    logic [GW-1:0]     r_gap_cnt;
    logic [DATA_W-1:0] r_data_out;
    logic              r_data_out_valid;
    logic              r_frame_done;
    logic [7:0]        r_drop_cnt;

    logic              w_sof;
    logic              w_wr_en;
    logic [AW-1:0]     w_wr_addr;
    logic              w_rd_en;
    logic [AW-1:0]     w_rd_addr;
    logic [DATA_W-1:0] w_rd_data;

    assign w_sof     = pix_in_valid & pix_sof;
    assign w_wr_en   = ((r_state == ST_IDLE) & w_sof) | ((r_state == ST_FILL) & pix_in_valid);
    assign w_wr_addr = w_sof ? '0 : r_wr_addr;

    // Beat counter value b drives output beat b-1 at the next edge; the RAM
    // read for pixel j is issued at count PAD_BEATS+j so its data lands on time.
    assign w_rd_en   = (r_state == ST_SEND) && (r_beat_cnt >= BW'(PAD_BEATS))
                       && (r_beat_cnt < BW'(BURST_LEN));
    assign w_rd_addr = AW'(r_beat_cnt - BW'(PAD_BEATS));

    sdp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (N_PIX),
        .ADDR_W (AW)
    ) u_frame_buf (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (pix_in),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_wr_addr        <= '0;
            r_beat_cnt       <= '0;
            r_gap_cnt        <= '0;
            r_data_out       <= '0;
            r_data_out_valid <= 1'b0;
            r_frame_done     <= 1'b0;
            r_drop_cnt       <= '0;
        end else begin
            r_data_out       <= '0;
            r_data_out_valid <= 1'b0;
            r_frame_done     <= 1'b0;

            // Any start-of-frame outside IDLE abandons a frame.
            if (w_sof && (r_state != ST_IDLE) && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_sof) begin
                        r_wr_addr <= AW'(1);
                        r_state   <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (w_sof) begin
                        r_wr_addr <= AW'(1);
                    end else if (pix_in_valid) begin
                        if (r_wr_addr == AW'(N_PIX - 1)) begin
                            r_wr_addr  <= '0;
                            r_beat_cnt <= '0;
                            r_state    <= ST_SEND;
                        end else begin
                            r_wr_addr <= r_wr_addr + 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    r_beat_cnt <= r_beat_cnt + 1'b1;
                    if (r_beat_cnt != '0) begin
                        r_data_out_valid <= 1'b1;
                        r_data_out       <= (r_beat_cnt > BW'(PAD_BEATS)) ? w_rd_data : '0;
                    end
                    if (r_beat_cnt == BW'(BURST_LEN)) begin
                        r_frame_done <= 1'b1;
                        r_beat_cnt   <= '0;
                        r_gap_cnt    <= '0;
                        r_state      <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == GW'(GAP_CYCLES)) begin
                        r_gap_cnt <= '0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_out       = r_data_out;
    assign data_out_valid = r_data_out_valid;
    assign frame_done     = r_frame_done;
    assign busy           = (r_state != ST_IDLE);
    assign drop_cnt       = r_drop_cnt;

endmodule : cnn_frame_feeder
`default_nettype wire

// File: tb/tb_cnn_frame_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cnn_frame_feeder
// Brief    : Self-checking bench: scenario table plus reset/stray sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cnn_frame_feeder;

    localparam int C_NPIX  = 784;
    localparam int C_BURST = 785;
    localparam int C_GAP   = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pix_in;
    logic       pix_in_valid;
    logic       pix_sof;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       frame_done;
    logic       busy;
    logic [7:0] drop_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cnn_frame_feeder dut (
        .clk            (clk),
        .rst            (rst),
        .pix_in         (pix_in),
        .pix_in_valid   (pix_in_valid),
        .pix_sof        (pix_sof),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .frame_done     (frame_done),
        .busy           (busy),
        .drop_cnt       (drop_cnt)
    );

    typedef struct {
        bit         gapped;
        bit         cmode;
        logic [7:0] cval;
        int         partial;
        int         s_from;
        int         s_len;
        bit         gap_sof;
        logic [7:0] exp_drop;
    } scen_t;

    scen_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        pix_in       = 8'h00;
        pix_in_valid = 1'b0;
        pix_sof      = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [7:0] exp_beat(input int k, input bit cmode, input logic [7:0] cval);
        if (k < 1) return 8'h00;
        if (cmode) return cval;
        return 8'((k - 1) % 256);
    endfunction

    task automatic feed_partial(input int n);
        for (int i = 0; i < n; i++) begin
            pix_in       = 8'(i);
            pix_sof      = (i == 0);
            pix_in_valid = 1'b1;
            tick();
        end
        clear_inputs();
    endtask

    // Leaves time just after the edge that wrote the last pixel.
    task automatic feed_frame(input bit gapped, input bit cmode, input logic [7:0] cval);
        for (int i = 0; i < C_NPIX; i++) begin
            pix_in       = cmode ? cval : 8'(i);
            pix_sof      = (i == 0);
            pix_in_valid = 1'b1;
            tick();
            if (gapped && i != C_NPIX - 1) begin
                pix_in_valid = 1'b0;
                pix_sof      = 1'b0;
                tick();
            end
        end
        clear_inputs();
    endtask

    task automatic check_burst(input string tag, input bit cmode, input logic [7:0] cval,
                               input int s_from, input int s_len, input bit gap_sof);
        int errs;
        int gerrs;
        bit inj;
        tick();
        chk({tag, "_t1_valid"}, 32'(data_out_valid), 32'd0);
        errs = 0;
        for (int k = 0; k < C_BURST; k++) begin
            tick();
            if (data_out_valid !== 1'b1 || data_out !== exp_beat(k, cmode, cval) ||
                frame_done !== (k == C_BURST - 1))
                errs++;
            inj          = (k >= s_from) && (k < s_from + s_len);
            pix_in       = 8'hEE;
            pix_in_valid = inj;
            pix_sof      = inj;
        end
        clear_inputs();
        chk({tag, "_burst_errs"}, 32'(errs), 32'd0);
        gerrs = 0;
        for (int g = 1; g <= C_GAP; g++) begin
            tick();
            if (data_out_valid !== 1'b0 || data_out !== 8'h00 || busy !== 1'b1 || frame_done !== 1'b0)
                gerrs++;
            pix_in_valid = gap_sof && (g == 5);
            pix_sof      = gap_sof && (g == 5);
        end
        clear_inputs();
        chk({tag, "_gap_errs"}, 32'(gerrs), 32'd0);
        tick();
        chk({tag, "_busy_after_gap"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int errs;
        rst = 1'b0;
        clear_inputs();

        tbl[0] = '{1'b0, 1'b0, 8'h00, 0,   0,   0, 1'b0, 8'd0};
        tbl[1] = '{1'b1, 1'b0, 8'h00, 0,   0,   0, 1'b0, 8'd0};
        tbl[2] = '{1'b0, 1'b1, 8'hA5, 300, 0,   0, 1'b0, 8'd1};
        tbl[3] = '{1'b0, 1'b0, 8'h00, 0,   100, 3, 1'b1, 8'd4};
        tbl[4] = '{1'b1, 1'b1, 8'h3C, 17,  0,   0, 1'b1, 8'd2};
        tbl[5] = '{1'b0, 1'b0, 8'h00, 0,   0, 300, 1'b0, 8'd255};

        do_reset();
        chk("rst_valid", 32'(data_out_valid), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);

        // Stray pixels without start-of-frame must be ignored in IDLE.
        errs = 0;
        for (int i = 0; i < 50; i++) begin
            pix_in       = 8'(i + 7);
            pix_in_valid = 1'b1;
            tick();
            if (busy !== 1'b0 || data_out_valid !== 1'b0) errs++;
        end
        clear_inputs();
        chk("stray_errs", 32'(errs), 32'd0);

        for (int s = 0; s < 6; s++) begin
            do_reset();
            if (tbl[s].partial > 0) feed_partial(tbl[s].partial);
            feed_frame(tbl[s].gapped, tbl[s].cmode, tbl[s].cval);
            check_burst($sformatf("scen%0d", s), tbl[s].cmode, tbl[s].cval,
                        tbl[s].s_from, tbl[s].s_len, tbl[s].gap_sof);
            chk($sformatf("scen%0d_drop", s), 32'(drop_cnt), 32'(tbl[s].exp_drop));
        end

        // Reset in the middle of a burst, at beat 400.
        do_reset();
        feed_frame(1'b0, 1'b0, 8'h00);
        tick();
        for (int k = 0; k <= 400; k++) tick();
        chk("mid_beat400", 32'(data_out), 32'(exp_beat(400, 1'b0, 8'h00)));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(data_out_valid), 32'd0);
        chk("mid_rst_data", 32'(data_out), 32'd0);
        chk("mid_rst_done", 32'(frame_done), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (data_out_valid !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0) errs++;
        end
        chk("mid_rst_quiet", 32'(errs), 32'd0);
        feed_frame(1'b0, 1'b1, 8'h5A);
        check_burst("post_rst", 1'b1, 8'h5A, 0, 0, 1'b0);
        chk("post_rst_drop", 32'(drop_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_cnn_frame_feeder
`default_nettype wire
